// File: rtl/alu_pkg.sv
// Opcode constants, control FSM encoding and opcode helpers shared by the
// pipelined ALU, its multiplier and the benches.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// XLEN iterations, full 2*XLEN-bit product held until the next start.
module alu_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);

  logic [2*XLEN-1:0] mcand_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;

  // done marks the edge that performs the final iteration, so the product is
  // complete in the cycle right after it.
  assign done    = busy_reg && (cnt_reg == CNT_W'(XLEN - 1));
  assign busy    = busy_reg;
  assign product = acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{XLEN{1'b0}}, a};
      acc_reg    <= '0;
      mplier_reg <= b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with a single registered output stage: single-cycle ops load
// the output on the accepting edge, multiplies run through an iterative unit.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            alu_carry,
  output logic            alu_zero,
  output logic            alu_ovf,
  output logic            alu_neg
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam bit MUL_ON  = (MUL_EN != 0);

  alu_state_t state_reg;
  alu_state_t state_next;

  logic              accept;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic              mul_hi_reg;
  logic [2*XLEN-1:0] mul_product;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN:0]      sum;
  logic [XLEN:0]      diff;
  logic [XLEN-1:0]    res_word;
  logic               res_carry;
  logic               res_ovf;

  logic               load_en;
  logic [XLEN-1:0]    load_word;
  logic               load_carry;
  logic               load_ovf;

  // Gated by rst_n so nothing is advertised while reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && MUL_ON && is_mul_op(alu_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mul_hi_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (mul_start) begin
        mul_hi_reg <= (alu_opcode == OP_MULHU);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (mul_start) state_next = MUL;
      MUL: begin
        if (mul_done) begin
          state_next = DONE;
        end else if (!mul_busy) begin
          state_next = IDLE;
        end
      end
      DONE: if (!out_valid || out_ready) state_next = DONE == DONE ? IDLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle datapath straight from the operands being accepted.
  always_comb begin
    sum       = {1'b0, alu_in_1} + {1'b0, alu_in_2};
    diff      = {1'b0, alu_in_1} - {1'b0, alu_in_2};
    shamt     = alu_in_2[SHAMT_W-1:0];
    res_word  = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        res_word  = sum[XLEN-1:0];
        res_carry = sum[XLEN];
        res_ovf   = (alu_in_1[XLEN-1] == alu_in_2[XLEN-1]) && (sum[XLEN-1] != alu_in_1[XLEN-1]);
      end
      OP_SUB: begin
        res_word  = diff[XLEN-1:0];
        res_carry = diff[XLEN];
        res_ovf   = (alu_in_1[XLEN-1] != alu_in_2[XLEN-1]) && (diff[XLEN-1] != alu_in_1[XLEN-1]);
      end
      OP_XOR:  res_word = alu_in_1 ^ alu_in_2;
      OP_OR:   res_word = alu_in_1 | alu_in_2;
      OP_AND:  res_word = alu_in_1 & alu_in_2;
      OP_SLL:  res_word = alu_in_1 << shamt;
      OP_SRL:  res_word = alu_in_1 >> shamt;
      OP_SRA:  res_word = $signed(alu_in_1) >>> shamt;
      OP_SLT:  res_word = {{(XLEN-1){1'b0}}, ($signed(alu_in_1) < $signed(alu_in_2))};
      OP_SLTU: res_word = {{(XLEN-1){1'b0}}, (alu_in_1 < alu_in_2)};
      default: res_word = '0;
    endcase
  end

  always_comb begin
    load_en    = 1'b0;
    load_word  = res_word;
    load_carry = res_carry;
    load_ovf   = res_ovf;
    if (state_reg == DONE) begin
      load_en    = !out_valid || out_ready;
      load_word  = mul_hi_reg ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
      load_carry = 1'b0;
      load_ovf   = 1'b0;
    end else if (accept && !mul_start) begin
      load_en = 1'b1;
    end
  end

  // Zero and negative are taken from the word being loaded so they always
  // describe the value that appears on alu_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      alu_carry <= 1'b0;
      alu_zero  <= 1'b0;
      alu_ovf   <= 1'b0;
      alu_neg   <= 1'b0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      alu_out   <= load_word;
      alu_carry <= load_carry;
      alu_zero  <= (load_word == '0);
      alu_ovf   <= load_ovf;
      alu_neg   <= load_word[XLEN-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    if (MUL_ON) begin : g_mul
      alu_mul_iter #(
        .XLEN(XLEN)
      ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (alu_in_1),
        .b       (alu_in_2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

endmodule
